// File: rtl/charlie_scan.sv
// Charlieplex LED matrix scanner: walks every off-diagonal (row, col) pair with a
// blanking cycle per slot, temporal PWM across frames, and a double-buffered frame load.
module charlie_scan #(
    parameter int PINS     = 8,
    parameter int PWM_BITS = 2,
    parameter int DWELL    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [PINS*PINS*PWM_BITS-1:0] fb_in,
    input  logic                         fb_valid,
    output logic                         fb_ready,
    output logic                         frame_start,
    output logic [PINS-1:0]              uio_out,
    output logic [PINS-1:0]              uio_oe
);
    localparam int FB_W = PINS * PINS * PWM_BITS;
    localparam int PW   = $clog2(PINS);
    localparam int DW   = $clog2(DWELL);

    localparam logic [PW-1:0]       LAST_IDX = PW'(PINS - 1);
    localparam logic [PW-1:0]       LAST_COL = PW'(PINS - 2);
    localparam logic [DW-1:0]       D_LAST   = DW'(DWELL - 1);
    localparam logic [PWM_BITS-1:0] P_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);

    // The slot counter is kept as its (row, col) decomposition; slot 0 is (0, 1).
    logic [PW-1:0]       row;
    logic [PW-1:0]       col;
    logic [DW-1:0]       d;
    logic [PWM_BITS-1:0] p;

    logic [FB_W-1:0] active;
    logic [FB_W-1:0] pending;
    logic            pending_full;

    logic                last_slot;
    logic                last_cycle;
    logic                slot0_blank;
    logic [PW-1:0]       row_nxt;
    logic [PW-1:0]       col_nxt;
    logic [PWM_BITS-1:0] level;
    logic [PINS-1:0]     oe_nxt;
    logic [PINS-1:0]     out_nxt;

    assign last_slot   = (row == LAST_IDX) && (col == LAST_COL);
    assign last_cycle  = enable && last_slot && (d == D_LAST);
    assign slot0_blank = (row == '0) && (col == PW'(1)) && (d == '0);
    assign fb_ready    = !rst && !pending_full;

    // Advance to the next slot in row-major order, stepping over the diagonal.
    always_comb begin
        int ci;
        row_nxt = row;
        col_nxt = col;
        ci      = int'(col) + 1;
        if (ci == int'(row)) begin
            ci = ci + 1;
        end
        if (last_slot) begin
            row_nxt = '0;
            col_nxt = PW'(1);
        end else if (ci > PINS - 1) begin
            row_nxt = row + 1'b1;
            col_nxt = '0;
        end else begin
            col_nxt = PW'(ci);
        end
    end

    always_comb begin
        level = '0;
        for (int r = 0; r < PINS; r++) begin
            for (int c = 0; c < PINS; c++) begin
                if (row == PW'(r) && col == PW'(c)) begin
                    level = active[(r*PINS+c)*PWM_BITS +: PWM_BITS];
                end
            end
        end
    end

    always_comb begin
        oe_nxt  = '0;
        out_nxt = '0;
        if (d != '0 && level > p) begin
            oe_nxt  = (PINS'(1) << row) | (PINS'(1) << col);
            out_nxt = PINS'(1) << row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row          <= '0;
            col          <= PW'(1);
            d            <= '0;
            p            <= '0;
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            uio_out      <= '0;
            uio_oe       <= '0;
            frame_start  <= 1'b0;
        end else begin
            if (enable) begin
                uio_out     <= out_nxt;
                uio_oe      <= oe_nxt;
                frame_start <= slot0_blank;
                if (d == D_LAST) begin
                    d   <= '0;
                    row <= row_nxt;
                    col <= col_nxt;
                    if (last_slot) begin
                        p <= (p == P_LAST) ? '0 : p + 1'b1;
                    end
                end else begin
                    d <= d + 1'b1;
                end
            end else begin
                uio_out     <= '0;
                uio_oe      <= '0;
                frame_start <= 1'b0;
                row         <= '0;
                col         <= PW'(1);
                d           <= '0;
                p           <= '0;
            end

            // A frame accepted on the boundary cycle itself waits for the next boundary.
            if (last_cycle && pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end else if (fb_valid && !pending_full) begin
                pending      <= fb_in;
                pending_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_charlie_scan.sv
// Randomised scoreboard bench for charlie_scan against a time-indexed reference model.
module tb_charlie_scan;
    localparam int PINS     = 8;
    localparam int PWM_BITS = 2;
    localparam int DWELL    = 4;
    localparam int S        = PINS * (PINS - 1);
    localparam int FRAME    = S * DWELL;
    localparam int LEVELS   = (1 << PWM_BITS) - 1;
    localparam int FB_W     = PINS * PINS * PWM_BITS;

    typedef logic [FB_W-1:0]     fb_t;
    typedef logic [2*PINS+1:0]   obs_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            fb_valid;
    logic            fb_ready;
    logic            frame_start;
    fb_t             fb_in;
    logic [PINS-1:0] uio_out;
    logic [PINS-1:0] uio_oe;

    charlie_scan #(.PINS(PINS), .PWM_BITS(PWM_BITS), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fb_in(fb_in), .fb_valid(fb_valid),
        .fb_ready(fb_ready), .frame_start(frame_start), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model: t counts cycles since scanning (re)started.
    int              t = 0;
    fb_t             m_active = '0;
    fb_t             m_pending = '0;
    bit              m_pf = 1'b0;
    bit              m_fs = 1'b0;
    logic [PINS-1:0] m_oe = '0;
    logic [PINS-1:0] m_out = '0;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cnt24 = 0;
    int   cnt_nz = 0;
    bit   dut_took;

    function automatic int bright(fb_t f, int r, int c);
        return int'(f[(r*PINS+c)*PWM_BITS +: PWM_BITS]);
    endfunction

    function automatic fb_t set_led(fb_t f, int r, int c, int v);
        fb_t g = f;
        g[(r*PINS+c)*PWM_BITS +: PWM_BITS] = PWM_BITS'(v);
        return g;
    endfunction

    function automatic fb_t rand_fb();
        fb_t f;
        for (int i = 0; i < FB_W; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    function automatic void model_edge();
        int s, d, p, r, k, c;
        bit boundary = 1'b0;
        if (rst) begin
            t = 0; m_active = '0; m_pending = '0; m_pf = 1'b0;
            m_fs = 1'b0; m_oe = '0; m_out = '0;
            return;
        end
        if (enable) begin
            d = t % DWELL;
            s = (t / DWELL) % S;
            p = (t / FRAME) % LEVELS;
            r = s / (PINS - 1);
            k = s % (PINS - 1);
            c = (k >= r) ? k + 1 : k;
            m_fs  = (s == 0 && d == 0);
            m_oe  = '0;
            m_out = '0;
            if (d != 0 && bright(m_active, r, c) > p) begin
                m_oe[r] = 1'b1; m_oe[c] = 1'b1; m_out[r] = 1'b1;
            end
            boundary = (s == S - 1 && d == DWELL - 1);
            t = (t + 1) % (FRAME * LEVELS);
        end else begin
            t = 0; m_fs = 1'b0; m_oe = '0; m_out = '0;
        end
        if (boundary && m_pf) begin
            m_active = m_pending; m_pf = 1'b0;
        end else if (fb_valid && !m_pf) begin
            m_pending = fb_in; m_pf = 1'b1;
        end
    endfunction

    task automatic step(input logic r, input logic e, input logic v, input fb_t f);
        rst = r; enable = e; fb_valid = v; fb_in = f;
        exp_q.push_back({m_fs, m_oe, m_out, ~r & ~m_pf});
        #2;
        dut_took = v && fb_ready;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, '0);
    endtask

    task automatic load(input fb_t f, input logic e);
        int n = 0;
        do begin
            step(1'b0, e, 1'b1, f);
            n++;
        end while (!dut_took && n < 2000);
        checks++;
        if (dut_took) passes++;
        else $display("FAIL load_accept: not accepted after %0d cycles, want accept", n);
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    always @(negedge clk) begin
        obs_t got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {frame_start, uio_oe, uio_out, fb_ready};
            checks++;
            if (got === want) passes++;
            else $display("FAIL scan_out @%0t: got fs=%0b oe=%02h out=%02h rdy=%0b, want fs=%0b oe=%02h out=%02h rdy=%0b",
                          $time, got[2*PINS+1], got[2*PINS:PINS+1], got[PINS:1], got[0],
                          want[2*PINS+1], want[2*PINS:PINS+1], want[PINS:1], want[0]);
            if (uio_oe == 8'h24 && uio_out == 8'h04) cnt24++;
            if (uio_oe != '0) cnt_nz++;
        end
    end

    initial begin
        fb_t f;
        logic en, v;
        rst = 1'b1; enable = 1'b0; fb_valid = 1'b0; fb_in = '0;
        @(posedge clk); #1;

        // Reset held with a valid offer: nothing captured, ready low, then high on release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, rand_fb());
        step(1'b0, 1'b0, 1'b0, '0);

        // Single LED at (2,5), brightness 3.
        f = set_led('0, 2, 5, 3);
        load(f, 1'b0);
        idle(FRAME, 1'b1);
        cnt24 = 0; cnt_nz = 0;
        idle(3 * FRAME + 8, 1'b1);
        check_eq("single_led_hits", cnt24, 9);
        check_eq("single_led_lit", cnt_nz, 9);

        // PWM levels 1, 2 and 0.
        f = set_led('0, 0, 1, 1);
        f = set_led(f, 0, 2, 2);
        f = set_led(f, 1, 0, 0);
        load(f, 1'b1);
        idle(5 * FRAME, 1'b1);

        // Back-to-back offers mid-frame.
        idle(37, 1'b1);
        load(rand_fb(), 1'b1);
        load(rand_fb(), 1'b1);
        idle(3 * FRAME, 1'b1);

        // Diagonal-only frame, then enable dropped and restored mid-frame.
        f = '0;
        for (int i = 0; i < PINS; i++) f = set_led(f, i, i, 3);
        load(f, 1'b1);
        idle(FRAME + 2, 1'b1);
        cnt_nz = 0;
        idle(90, 1'b1);
        idle(10, 1'b0);
        idle(2 * FRAME, 1'b1);
        check_eq("diag_dark", cnt_nz, 0);

        // Reset while a frame is pending.
        load(set_led(rand_fb(), 3, 4, 3), 1'b1);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        cnt_nz = 0;
        idle(2 * FRAME, 1'b1);
        check_eq("reset_discard_dark", cnt_nz, 0);

        // Random traffic with occasional enable drops.
        en = 1'b1; v = 1'b0; f = '0;
        for (int i = 0; i < 4000; i++) begin
            if (en && $urandom_range(0, 299) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
            if (!v && $urandom_range(0, 99) == 0) begin
                v = 1'b1; f = rand_fb();
            end
            step(1'b0, en, v, f);
            if (dut_took) v = 1'b0;
        end

        step(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk); #1;
        check_eq("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/charlie_scan.md
# charlie_scan

Parametrised charlieplex LED matrix scanner with its own scan timing. It drives `PINS` tri-state pins so that up to `PINS*(PINS-1)` LEDs can be addressed, and sits between the frame-buffer/pattern logic and the `uio` pad bus. Compared with the single-bit, externally indexed driver, it adds:

- an internal scan sequencer that skips diagonal positions,
- per-LED multi-level brightness using temporal PWM across frames,
- a blanking cycle between LEDs to suppress ghosting,
- a double-buffered frame load with a valid/ready handshake, swapped only at frame boundaries.

## Interface
Parameters:
- `PINS`, default 8: number of charlieplex pins. Legal range 3..8.
- `PWM_BITS`, default 2: brightness bits per LED. Legal range 1..4.
- `DWELL`, default 4: clock cycles per LED slot, including 1 blanking cycle. Legal range ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  scan enable.
- `fb_in`  in  `PINS*PINS*PWM_BITS`  frame data. Brightness of row r, col c is `fb_in[(r*PINS+c)*PWM_BITS +: PWM_BITS]`. Diagonal entries are ignored.
- `fb_valid`  in  1  producer offers `fb_in`.
- `fb_ready`  out  1  pending buffer is empty.
- `frame_start`  out  1  one-cycle pulse aligned with the first output cycle of slot 0.
- `uio_out`  out  `PINS`  pin drive levels.
- `uio_oe`  out  `PINS`  pin output enables (1 = drive).

## Operation
- **Slot order:** row-major over (r,c), skipping r==c.
  - Slot number is `s = r*(PINS-1) + (c>r ? c-1 : c)`.
  - `S = PINS*(PINS-1)` slots per frame; frame length is `S*DWELL` cycles.
- **Counters:** dwell counter `d` runs 0..DWELL-1; slot counter `s` runs 0..S-1; PWM phase `p` runs 0..2^PWM_BITS-2.
  - `d` wraps to 0 and increments `s`.
  - `s` wraps to 0 and increments `p`.
  - `p` wraps to 0 after 2^PWM_BITS-2.
- **Blanking:** when d==0, all `uio_oe` and `uio_out` bits are 0.
- **Drive:** when d≥1, the LED is lit if `active[r][c] > p` (unsigned compare).
  - Lit: `uio_oe[r]=uio_oe[c]=1`, `uio_out[r]=1`, all other `uio_out` bits 0.
  - Unlit: all bits 0.
  - Brightness 0 is never lit. Maximum brightness (2^PWM_BITS-1) is lit every frame. Brightness b is lit in b of the 2^PWM_BITS-1 frames.
- **Double buffer:**
  - `fb_ready = !pending_full`.
  - On `fb_valid && fb_ready`, `fb_in` is captured into `pending` and `pending_full` is set.
  - On the last cycle of a frame (s==S-1, d==DWELL-1, enable high), if `pending_full` was already set at the start of that cycle, `pending` is copied to `active` and `pending_full` is cleared.
  - Data accepted in that same last cycle is not swapped until the next frame boundary.
  - `active` never changes mid-frame.
- **enable low:**
  - `d`, `s` and `p` are forced to 0. Outputs are 0 from the next cycle.
  - The handshake still operates, and `pending` is held; no swap occurs while disabled.
  - After re-enable, scanning starts at slot 0, d==0, and `frame_start` pulses.
- **Reset:**
  - All outputs 0; `fb_ready` is 0 while `rst` is high and 1 in the first cycle after release.
  - `active` and `pending` are cleared to 0 and `pending_full` is cleared.
  - `d`, `s` and `p` are 0.
  - Reset mid-frame discards any pending frame.

## Timing
- Outputs are registered. The pattern for counter state (s,d) appears on `uio_out`/`uio_oe` one cycle after the counters hold (s,d).
- `frame_start` is registered with the same alignment, so it is high exactly during the blanking cycle of slot 0.
- With enable high, the first `frame_start` occurs 1 cycle after enable is sampled high (or after reset release with enable high).
- `fb_ready` falls the cycle after an accept. It rises the cycle after the frame-boundary swap.
- New `active` data first affects the outputs of slot 0 of the next frame.
- With default parameters: frame length 224 cycles; PWM period 3 frames.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `fb_valid`=1. Required: `uio_out`=0, `uio_oe`=0, `fb_ready`=0 throughout, no capture, and `fb_ready`=1 in the cycle after release.
- **Single LED:** load brightness 3 at (r=2, c=5) only, enable. In the frame after the swap, slot 18 (output cycles 72..75 after `frame_start`) must show: 1 cycle all-zero, then 3 cycles of `uio_oe`=0x24, `uio_out`=0x04. All other cycles are 0, repeating every frame.
- **PWM:** load (0,1)=1, (0,2)=2, (1,0)=0. Over 3 frames, (0,1) is lit only in the p==0 frame, (0,2) in the p==0 and p==1 frames, and (1,0) never.
- **Handshake:** offer frame A then frame B back-to-back mid-frame.
  - A is accepted and `fb_ready` drops; B is held.
  - Outputs keep the old pattern until the boundary, then switch to A.
  - B is accepted after `fb_ready` reasserts and appears one frame later.
- **Diagonal and enable:** set all diagonal entries to 3 and everything else to 0. `uio_oe` must stay 0 for the whole frame. Drop `enable` mid-frame: outputs are 0 the next cycle; on re-enable, `frame_start` pulses and slot 0 restarts.
- **Reset mid-operation:** assert `rst` while `pending_full`=1 mid-frame. Required: the pending frame is discarded, the active frame is zero, and all outputs stay 0 after release until a new load completes.
